// File: rtl/lsu_pkg.sv
// Shared constants and decode helpers for the load/store bus port.
// State codes, store/load format codes, byte-mask sizes and the unsigned-load decode.
package lsu_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_REQ0  = 3'd1;
  localparam logic [2:0] ST_WAIT0 = 3'd2;
  localparam logic [2:0] ST_REQ1  = 3'd3;
  localparam logic [2:0] ST_WAIT1 = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  localparam logic [3:0] WSTRB_BYTE = 4'b0001;
  localparam logic [3:0] WSTRB_HALF = 4'b0011;
  localparam logic [3:0] WSTRB_WORD = 4'b1111;

  localparam logic [3:0] LOAD_LB  = 4'b0001;
  localparam logic [3:0] LOAD_LH  = 4'b0011;
  localparam logic [3:0] LOAD_LW  = 4'b1111;
  localparam logic [3:0] LOAD_LBU = 4'b1001;
  localparam logic [3:0] LOAD_LHU = 4'b1011;

  localparam logic [3:0] MASK_BYTE = 4'b0001;
  localparam logic [3:0] MASK_HALF = 4'b0011;
  localparam logic [3:0] MASK_WORD = 4'b1111;

  function automatic logic [3:0] store_mask(input logic [3:0] wstrb);
    case (wstrb)
      WSTRB_BYTE: return MASK_BYTE;
      WSTRB_HALF: return MASK_HALF;
      WSTRB_WORD: return MASK_WORD;
      default:    return MASK_WORD;
    endcase
  endfunction

  // lw and lh share the low two code bits, so the full code is decoded.
  function automatic logic [3:0] load_mask(input logic [3:0] code);
    case (code)
      LOAD_LB, LOAD_LBU: return MASK_BYTE;
      LOAD_LH, LOAD_LHU: return MASK_HALF;
      LOAD_LW:           return MASK_WORD;
      default:           return MASK_WORD;
    endcase
  endfunction

  function automatic logic load_unsigned(input logic [3:0] code);
    return code[3] & ~code[2];
  endfunction

endpackage

// File: rtl/lsu_bus_port_load_align_ext.sv
// Combinational load aligner: shifts the two captured bus words down by the byte offset,
// then masks to the access size with sign or zero extension.
module load_align_ext
  import lsu_pkg::*;
(
  input  logic [63:0] data,
  input  logic [1:0]  off,
  input  logic [3:0]  mask,
  input  logic        uns,
  output logic [31:0] result
);

  logic [31:0] lo;

  always_comb begin
    lo = 32'(data >> {off, 3'b000});
    case (mask)
      MASK_BYTE: result = {{24{~uns & lo[7]}}, lo[7:0]};
      MASK_HALF: result = {{16{~uns & lo[15]}}, lo[15:0]};
      default:   result = lo;
    endcase
  end

endmodule

// File: rtl/lsu_bus_port.sv
// Load/store unit driving a req/gnt/rvalid data bus, stalling the core per access.
// LSU_MISALIGN_SPLIT_EN: split word-crossing accesses in two; otherwise flag them as misaligned.
module lsu_bus_port
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              req_valid_i,
  input  logic              mem_write_i,
  input  logic              mem_read_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [3:0]        wstrb_i,
  input  logic [3:0]        wstrb_load_i,
  output logic              stall_o,
  output logic              done_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              misalign_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [3:0]        bus_be_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic              bus_gnt_i,
  input  logic              bus_rvalid_i,
  input  logic [DATA_W-1:0] bus_rdata_i
);

  logic [2:0]        state_reg, state_next;
  logic [ADDR_W-3:0] word_reg;
  logic [1:0]        off_reg;
  logic [3:0]        mask_reg;
  logic              uns_reg, we_reg, misalign_reg;
  logic [3:0]        be_lo_reg;
  logic [31:0]       wd_lo_reg, w0_reg, rdata_reg;
  logic [31:0]       ext_data;
  logic [63:0]       load_words;

  logic       start;
  logic [3:0] mask_in;
  logic [7:0] be8_in;
  logic       misalign_in;

  assign start   = req_valid_i & (mem_read_i | mem_write_i);
  assign mask_in = mem_write_i ? store_mask(wstrb_i) : load_mask(wstrb_load_i);
  assign be8_in  = {4'b0000, mask_in} << addr_i[1:0];

`ifdef LSU_MISALIGN_SPLIT_EN
  logic [3:0]  be_hi_reg;
  logic [31:0] wd_hi_reg, w1_reg;
  logic [63:0] wd64_in;
  assign wd64_in     = {32'h0, wdata_i} << {addr_i[1:0], 3'b000};
  assign misalign_in = 1'b0;
  assign load_words  = {w1_reg, w0_reg};
`else
  logic [31:0] wd_lo_in;
  assign wd_lo_in    = wdata_i << {addr_i[1:0], 3'b000};
  // Anything not fully inside one word, plus half accesses at odd offset 1.
  assign misalign_in = (|be8_in[7:4]) | ((mask_in == MASK_HALF) && (addr_i[1:0] == 2'd1));
  assign load_words  = {32'h0, w0_reg};
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (start) state_next = misalign_in ? ST_DONE : ST_REQ0;
      ST_REQ0:  if (bus_gnt_i) state_next = ST_WAIT0;
`ifdef LSU_MISALIGN_SPLIT_EN
      ST_WAIT0: if (bus_rvalid_i) state_next = (|be_hi_reg) ? ST_REQ1 : ST_DONE;
      ST_REQ1:  if (bus_gnt_i) state_next = ST_WAIT1;
      ST_WAIT1: if (bus_rvalid_i) state_next = ST_DONE;
`else
      ST_WAIT0: if (bus_rvalid_i) state_next = ST_DONE;
`endif
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_reg    <= ST_IDLE;
      word_reg     <= '0;
      off_reg      <= '0;
      mask_reg     <= '0;
      uns_reg      <= 1'b0;
      we_reg       <= 1'b0;
      misalign_reg <= 1'b0;
      be_lo_reg    <= '0;
      wd_lo_reg    <= '0;
      w0_reg       <= '0;
      rdata_reg    <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
      be_hi_reg    <= '0;
      wd_hi_reg    <= '0;
      w1_reg       <= '0;
`endif
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_IDLE && start) begin
        word_reg     <= addr_i[ADDR_W-1:2];
        off_reg      <= addr_i[1:0];
        mask_reg     <= mask_in;
        uns_reg      <= load_unsigned(wstrb_load_i) & ~mem_write_i;
        we_reg       <= mem_write_i;
        misalign_reg <= misalign_in;
        be_lo_reg    <= be8_in[3:0];
`ifdef LSU_MISALIGN_SPLIT_EN
        be_hi_reg    <= be8_in[7:4];
        wd_lo_reg    <= wd64_in[31:0];
        wd_hi_reg    <= wd64_in[63:32];
`else
        wd_lo_reg    <= wd_lo_in;
`endif
      end
      if (state_reg == ST_WAIT0 && bus_rvalid_i) w0_reg <= bus_rdata_i;
`ifdef LSU_MISALIGN_SPLIT_EN
      if (state_reg == ST_WAIT1 && bus_rvalid_i) w1_reg <= bus_rdata_i;
`endif
      if (state_reg == ST_DONE) rdata_reg <= rdata_o;
    end
  end

  load_align_ext u_align (
    .data   (load_words),
    .off    (off_reg),
    .mask   (mask_reg),
    .uns    (uns_reg),
    .result (ext_data)
  );

  assign done_o     = (state_reg == ST_DONE);
  assign misalign_o = done_o & misalign_reg;
  assign stall_o    = (state_reg == ST_IDLE) ? start : ~done_o;
  assign bus_req_o  = (state_reg == ST_REQ0) || (state_reg == ST_REQ1);
  assign bus_we_o   = bus_req_o & we_reg;

`ifdef LSU_MISALIGN_SPLIT_EN
  logic second;
  assign second      = (state_reg == ST_REQ1);
  assign bus_addr_o  = !bus_req_o ? '0 :
                       {(second ? word_reg + (ADDR_W-2)'(1) : word_reg), 2'b00};
  assign bus_be_o    = !bus_req_o ? '0 : (second ? be_hi_reg : be_lo_reg);
  assign bus_wdata_o = !bus_req_o ? '0 : (second ? wd_hi_reg : wd_lo_reg);
`else
  assign bus_addr_o  = bus_req_o ? {word_reg, 2'b00} : '0;
  assign bus_be_o    = bus_req_o ? be_lo_reg : '0;
  assign bus_wdata_o = bus_req_o ? wd_lo_reg : '0;
`endif

  // Load result is live during DONE and then held in rdata_reg; stores leave it alone.
  always_comb begin
    rdata_o = rdata_reg;
    if (done_o && !we_reg) rdata_o = misalign_reg ? '0 : ext_data;
  end

endmodule

// File: tb/tb_lsu_bus_port.sv
// Directed bench for lsu_bus_port: stores, signed/unsigned loads, backpressure,
// reset mid-access, and misaligned or split accesses depending on LSU_MISALIGN_SPLIT_EN.
module tb_lsu_bus_port;

  logic        clk_i = 1'b0;
  logic        reset_ni = 1'b0;
  logic        req_valid_i = 1'b0, mem_write_i = 1'b0, mem_read_i = 1'b0;
  logic [31:0] addr_i = '0, wdata_i = '0;
  logic [3:0]  wstrb_i = '0, wstrb_load_i = '0;
  logic        stall_o, done_o, misalign_o, bus_req_o, bus_we_o;
  logic [31:0] rdata_o, bus_addr_o, bus_wdata_o;
  logic [3:0]  bus_be_o;
  logic        bus_gnt_i = 1'b0, bus_rvalid_i = 1'b0;
  logic [31:0] bus_rdata_i = '0;

  int total = 0;
  int bad = 0;

  always #5 clk_i = ~clk_i;

  lsu_bus_port dut (
    .clk_i        (clk_i),
    .reset_ni     (reset_ni),
    .req_valid_i  (req_valid_i),
    .mem_write_i  (mem_write_i),
    .mem_read_i   (mem_read_i),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .wstrb_i      (wstrb_i),
    .wstrb_load_i (wstrb_load_i),
    .stall_o      (stall_o),
    .done_o       (done_o),
    .rdata_o      (rdata_o),
    .misalign_o   (misalign_o),
    .bus_req_o    (bus_req_o),
    .bus_we_o     (bus_we_o),
    .bus_addr_o   (bus_addr_o),
    .bus_be_o     (bus_be_o),
    .bus_wdata_o  (bus_wdata_o),
    .bus_gnt_i    (bus_gnt_i),
    .bus_rvalid_i (bus_rvalid_i),
    .bus_rdata_i  (bus_rdata_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_req(input logic wr, input logic rd, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] strb, input logic [3:0] lcode);
    req_valid_i = 1'b1; mem_write_i = wr; mem_read_i = rd;
    addr_i = addr; wdata_i = wdata; wstrb_i = strb; wstrb_load_i = lcode;
  endtask

  task automatic clear_req();
    req_valid_i = 1'b0; mem_write_i = 1'b0; mem_read_i = 1'b0;
    addr_i = 32'hDEAD_BEEF; wdata_i = 32'h5A5A_5A5A; wstrb_i = 4'b0110; wstrb_load_i = 4'b0110;
  endtask

  // Single-word access; gdly extra REQ cycles before gnt, rdly extra WAIT cycles before rvalid.
  task automatic do_access(input string tag, input logic wr, input logic rd, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] strb, input logic [3:0] lcode,
                           input logic [31:0] rword, input int gdly, input int rdly,
                           input logic [31:0] exp_addr, input logic [3:0] exp_be,
                           input logic [31:0] exp_wdata, input logic [31:0] exp_rdata);
    drive_req(wr, rd, addr, wdata, strb, lcode);
    #1;
    chk({tag, " stall_accept"}, 32'(stall_o), 32'd1);
    step();
    clear_req();
    for (int i = 0; i <= gdly; i++) begin
      chk({tag, " bus_req"}, 32'(bus_req_o), 32'd1);
      chk({tag, " bus_addr"}, bus_addr_o, exp_addr);
      chk({tag, " bus_be"}, 32'(bus_be_o), 32'(exp_be));
      chk({tag, " bus_wdata"}, bus_wdata_o, exp_wdata);
      chk({tag, " bus_we"}, 32'(bus_we_o), 32'(wr));
      chk({tag, " stall_req"}, 32'(stall_o), 32'd1);
      if (i == gdly) bus_gnt_i = 1'b1;
      step();
    end
    bus_gnt_i = 1'b0;
    chk({tag, " req_drop"}, 32'(bus_req_o), 32'd0);
    chk({tag, " stall_wait"}, 32'(stall_o), 32'd1);
    for (int i = 0; i < rdly; i++) begin
      step();
      chk({tag, " stall_wait_n"}, 32'(stall_o), 32'd1);
      chk({tag, " done_early"}, 32'(done_o), 32'd0);
    end
    bus_rvalid_i = 1'b1; bus_rdata_i = rword;
    step();
    bus_rvalid_i = 1'b0; bus_rdata_i = 32'hA5A5_A5A5;
    chk({tag, " done"}, 32'(done_o), 32'd1);
    chk({tag, " stall_done"}, 32'(stall_o), 32'd0);
    chk({tag, " misalign"}, 32'(misalign_o), 32'd0);
    chk({tag, " rdata"}, rdata_o, exp_rdata);
    step();
    chk({tag, " done_pulse"}, 32'(done_o), 32'd0);
    chk({tag, " rdata_hold"}, rdata_o, exp_rdata);
    $display("txn %s: addr=0x%08h rdata=0x%08h", tag, addr, rdata_o);
  endtask

  task automatic do_misalign(input string tag, input logic wr, input logic rd, input logic [31:0] addr,
                             input logic [3:0] strb, input logic [3:0] lcode, input logic [31:0] exp_rdata);
    drive_req(wr, rd, addr, 32'h1234_5678, strb, lcode);
    #1;
    chk({tag, " stall_accept"}, 32'(stall_o), 32'd1);
    step();
    clear_req();
    chk({tag, " done"}, 32'(done_o), 32'd1);
    chk({tag, " misalign"}, 32'(misalign_o), 32'd1);
    chk({tag, " no_bus_req"}, 32'(bus_req_o), 32'd0);
    chk({tag, " stall_done"}, 32'(stall_o), 32'd0);
    chk({tag, " rdata"}, rdata_o, exp_rdata);
    step();
    chk({tag, " done_pulse"}, 32'(done_o), 32'd0);
    chk({tag, " misalign_pulse"}, 32'(misalign_o), 32'd0);
    chk({tag, " no_bus_req_after"}, 32'(bus_req_o), 32'd0);
    $display("txn %s: addr=0x%08h misaligned", tag, addr);
  endtask

  initial begin
    #12;
    chk("rst stall", 32'(stall_o), 32'd0);
    chk("rst done", 32'(done_o), 32'd0);
    chk("rst misalign", 32'(misalign_o), 32'd0);
    chk("rst bus_req", 32'(bus_req_o), 32'd0);
    chk("rst bus_we", 32'(bus_we_o), 32'd0);
    chk("rst bus_addr", bus_addr_o, 32'h0);
    chk("rst bus_be", 32'(bus_be_o), 32'h0);
    chk("rst bus_wdata", bus_wdata_o, 32'h0);
    chk("rst rdata", rdata_o, 32'h0);
    reset_ni = 1'b1;
    step();
    chk("idle stall", 32'(stall_o), 32'd0);

    do_access("sb_0x102", 1, 0, 32'h102, 32'h0000_00AB, 4'b0001, 4'b0000, 32'h0, 0, 0,
              32'h100, 4'b0100, 32'h00AB_0000, 32'h0);
    do_access("lb_0x203", 0, 1, 32'h203, 32'h0, 4'b0000, 4'b0001, 32'h80FF_FFFF, 0, 0,
              32'h200, 4'b1000, 32'h0, 32'hFFFF_FF80);
    do_access("lbu_0x203", 0, 1, 32'h203, 32'h0, 4'b0000, 4'b1001, 32'h80FF_FFFF, 0, 0,
              32'h200, 4'b1000, 32'h0, 32'h0000_0080);
    do_access("sw_rw_0x10c", 1, 1, 32'h10C, 32'h1122_3344, 4'b1111, 4'b0001, 32'h0, 0, 0,
              32'h10C, 4'b1111, 32'h1122_3344, 32'h0000_0080);
    do_access("sh_bp_0x20a", 1, 0, 32'h20A, 32'hFFFF_1234, 4'b0011, 4'b0000, 32'h0, 3, 2,
              32'h208, 4'b1100, 32'h1234_0000, 32'h0000_0080);
    do_access("lh_0x502", 0, 1, 32'h502, 32'h0, 4'b0000, 4'b0011, 32'hBEEF_1234, 0, 0,
              32'h500, 4'b1100, 32'h0, 32'hFFFF_BEEF);
    do_access("lhu_0x502", 0, 1, 32'h502, 32'h0, 4'b0000, 4'b1011, 32'hBEEF_1234, 0, 0,
              32'h500, 4'b1100, 32'h0, 32'h0000_BEEF);
    do_access("lw_0x600", 0, 1, 32'h600, 32'h0, 4'b0000, 4'b1111, 32'hCAFE_F00D, 1, 1,
              32'h600, 4'b1111, 32'h0, 32'hCAFE_F00D);
    do_access("lb_0x700", 0, 1, 32'h700, 32'h0, 4'b0000, 4'b0001, 32'hFFFF_FF7F, 0, 0,
              32'h700, 4'b0001, 32'h0, 32'h0000_007F);

`ifdef LSU_MISALIGN_SPLIT_EN
    drive_req(0, 1, 32'h306, 32'h0, 4'b0000, 4'b1111);
    #1;
    chk("split stall_accept", 32'(stall_o), 32'd1);
    step();
    clear_req();
    chk("split req0", 32'(bus_req_o), 32'd1);
    chk("split addr0", bus_addr_o, 32'h304);
    chk("split be0", 32'(bus_be_o), 32'b1100);
    bus_gnt_i = 1'b1;
    step();
    bus_gnt_i = 1'b0;
    chk("split wait0", 32'(bus_req_o), 32'd0);
    bus_rvalid_i = 1'b1; bus_rdata_i = 32'h4433_2211;
    step();
    bus_rvalid_i = 1'b0;
    chk("split req1", 32'(bus_req_o), 32'd1);
    chk("split addr1", bus_addr_o, 32'h308);
    chk("split be1", 32'(bus_be_o), 32'b0011);
    chk("split no_done", 32'(done_o), 32'd0);
    bus_gnt_i = 1'b1;
    step();
    bus_gnt_i = 1'b0;
    bus_rvalid_i = 1'b1; bus_rdata_i = 32'h8877_6655;
    step();
    bus_rvalid_i = 1'b0;
    chk("split done", 32'(done_o), 32'd1);
    chk("split misalign", 32'(misalign_o), 32'd0);
    chk("split rdata", rdata_o, 32'h6655_4433);
    step();
    chk("split done_pulse", 32'(done_o), 32'd0);
    $display("txn split_lw_0x306: rdata=0x%08h", rdata_o);
`else
    do_misalign("sw_mis_0x003", 1, 0, 32'h003, 4'b1111, 4'b0000, 32'h0000_007F);
    do_misalign("lh_mis_0x401", 0, 1, 32'h401, 4'b0000, 4'b0011, 32'h0);
    do_access("lb_0x703", 0, 1, 32'h703, 32'h0, 4'b0000, 4'b0001, 32'h9000_0000, 0, 0,
              32'h700, 4'b1000, 32'h0, 32'hFFFF_FF90);
    do_misalign("lw_mis_0x402", 0, 1, 32'h402, 4'b0000, 4'b1111, 32'h0);
    do_misalign("lhu_mis_0x403", 0, 1, 32'h403, 4'b0000, 4'b1011, 32'h0);
`endif

    // Reset while waiting for the response.
    drive_req(0, 1, 32'h800, 32'h0, 4'b0000, 4'b1111);
    step();
    clear_req();
    bus_gnt_i = 1'b1;
    step();
    bus_gnt_i = 1'b0;
    chk("rstmid stall_before", 32'(stall_o), 32'd1);
    reset_ni = 1'b0;
    #1;
    chk("rstmid stall", 32'(stall_o), 32'd0);
    chk("rstmid bus_req", 32'(bus_req_o), 32'd0);
    chk("rstmid done", 32'(done_o), 32'd0);
    chk("rstmid rdata", rdata_o, 32'h0);
    step();
    reset_ni = 1'b1;
    bus_rvalid_i = 1'b1; bus_rdata_i = 32'h1111_2222;
    step();
    bus_rvalid_i = 1'b0;
    chk("rstmid stray_rvalid done", 32'(done_o), 32'd0);
    chk("rstmid stray_rvalid stall", 32'(stall_o), 32'd0);
    chk("rstmid stray_rvalid req", 32'(bus_req_o), 32'd0);
    step();
    chk("rstmid idle done", 32'(done_o), 32'd0);
    $display("txn rst_mid_wait0: abandoned");
    do_access("lw_after_rst", 0, 1, 32'h900, 32'h0, 4'b0000, 4'b1111, 32'h0BAD_CAFE, 0, 0,
              32'h900, 4'b1111, 32'h0, 32'h0BAD_CAFE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
